axi_lite_fifo_slave: RTL and testbench

AXI-Lite responder (slave) peripheral with the codebase's burst extension (wlast/rlast). It sits behind axi_interconnect as a loopback mailbox. Write bursts to DATA push words into an internal FIFO. Read bursts from DATA pop and return the stored words, with rlast on the final beat. Status and count registers are single-beat reads, and rx_ready_int flags pending data.

---
 rtl/axi_lite_fifo_slave_if.sv | 32 +++
 rtl/axi_lite_fifo_slave.sv | 206 ++++++++++++++++++++
 tb/tb_axi_lite_fifo_slave.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_fifo_slave_if.sv
// AXI-Lite bus bundle (with wlast/rlast burst extension) for the FIFO mailbox slave.
// Every channel transfers on a rising aclk edge where valid && ready; once valid rises the
// source holds its payload stable until that edge, and ready may depend on valid.
interface axi_lite_fifo_slave_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awvalid, wdata, wlast, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rlast, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wlast, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rlast, rvalid
  );
endinterface

// File: rtl/axi_lite_fifo_slave.sv
// Loopback mailbox: DATA write bursts push into a FIFO, DATA read bursts pop it back out.
// COUNT/STATUS are single-beat reads, CTRL bit0 flushes; write and read FSMs run independently.
module axi_lite_fifo_slave #(
  parameter int DEPTH      = 16,
  parameter int MAX_RBURST = 16,
  parameter int BRESP_WAIT = 1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi_lite_fifo_slave_if.slave  bus,
  output logic                  rx_ready_int,
  output logic [1:0]            w_state_dbg,
  output logic                  r_state_dbg
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_RBURST + 1);

  localparam logic [3:0] OFF_DATA   = 4'h0;
  localparam logic [3:0] OFF_COUNT  = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_CTRL   = 4'hC;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e w_state;
  r_state_e r_state;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  logic [3:0]    w_addr;
  logic          w_err;
  logic [3:0]    r_addr;
  logic [BW-1:0] r_left;
  logic          r_zero;
  logic [BW-1:0] beats_first;

  logic w_beat, r_beat, flush, pop, push_req, push, drop_err, beat_err;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{bus.awaddr[31:4], bus.araddr[31:4]};

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  assign w_beat   = (w_state == W_DATA) && bus.wvalid && bus.wready;
  assign r_beat   = (r_state == R_DATA) && bus.rvalid && bus.rready;
  assign flush    = w_beat && (w_addr == OFF_CTRL) && bus.wdata[0];
  assign pop      = r_beat && (r_addr == OFF_DATA) && !r_zero;
  assign push_req = w_beat && (w_addr == OFF_DATA);
  // A full FIFO still takes the word when the same cycle pops one out.
  assign push     = push_req && !flush && (!full || pop);
  assign drop_err = push_req && full && !pop;
  assign beat_err = drop_err || (w_beat && (w_addr[1:0] != 2'b00));

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

  always_comb begin
    if (int'(count) > MAX_RBURST) beats_first = BW'(MAX_RBURST);
    else                          beats_first = BW'(count);
  end

  always_ff @(posedge aclk) begin
    if (push) mem[wr_ptr] <= bus.wdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_ready_int <= 1'b0;
    end else begin
      rx_ready_int <= (count != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state     <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= 2'b00;
      w_addr      <= '0;
      w_err       <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          bus.awready <= bus.awvalid && !bus.awready;
          if (bus.awvalid && bus.awready) begin
            bus.awready <= 1'b0;
            bus.wready  <= 1'b1;
            w_addr      <= bus.awaddr[3:0];
            w_err       <= 1'b0;
            w_state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat) begin
            if (beat_err) w_err <= 1'b1;
            if (bus.wlast) begin
              bus.wready <= 1'b0;
              bus.bvalid <= 1'b1;
              bus.bresp  <= (w_err || beat_err) ? 2'b10 : 2'b00;
              w_state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BRESP_WAIT == 0 || bus.bready) begin
            bus.bvalid <= 1'b0;
            bus.bresp  <= 2'b00;
            w_state    <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rlast   <= 1'b0;
      bus.rdata   <= '0;
      r_addr      <= '0;
      r_left      <= '0;
      r_zero      <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          bus.arready <= bus.arvalid && !bus.arready;
          if (bus.arvalid && bus.arready) begin
            bus.arready <= 1'b0;
            bus.rvalid  <= 1'b1;
            r_addr      <= bus.araddr[3:0];
            r_zero      <= 1'b0;
            r_left      <= BW'(1);
            bus.rlast   <= 1'b1;
            r_state     <= R_DATA;
            case (bus.araddr[3:0])
              OFF_DATA: begin
                // An empty FIFO still answers with one zero beat that pops nothing.
                r_left    <= empty ? BW'(1) : beats_first;
                bus.rlast <= empty || (beats_first == BW'(1));
                r_zero    <= empty || flush;
                bus.rdata <= (empty || flush) ? 32'h0 : mem[rd_ptr];
              end
              OFF_COUNT:  bus.rdata <= 32'(count);
              OFF_STATUS: bus.rdata <= {30'h0, full, empty};
              default:    bus.rdata <= 32'h0;
            endcase
          end
        end
        R_DATA: begin
          if (r_beat) begin
            if (bus.rlast) begin
              bus.rvalid <= 1'b0;
              bus.rlast  <= 1'b0;
              bus.rdata  <= 32'h0;
              r_state    <= R_IDLE;
            end else begin
              r_left    <= r_left - 1'b1;
              bus.rlast <= (r_left == BW'(2));
              if (r_zero || flush) begin
                r_zero    <= 1'b1;
                bus.rdata <= 32'h0;
              end else begin
                bus.rdata <= mem[rd_ptr + 1'b1];
              end
            end
          end else if (flush && (r_addr == OFF_DATA)) begin
            // The word on the bus was flushed before being taken, so it is replaced by zero.
            r_zero    <= 1'b1;
            bus.rdata <= 32'h0;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_fifo_slave.sv
// Directed bench for axi_lite_fifo_slave: AXI master driver tasks, FIFO scoreboard, summary.
module tb_axi_lite_fifo_slave;
  localparam int DEPTH      = 32;
  localparam int MAX_RBURST = 16;

  logic       aclk = 1'b0;
  logic       aresetn;
  logic       rx_ready_int;
  logic [1:0] w_state_dbg;
  logic       r_state_dbg;

  axi_lite_fifo_slave_if bus();

  axi_lite_fifo_slave #(.DEPTH(DEPTH), .MAX_RBURST(MAX_RBURST), .BRESP_WAIT(1)) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .bus          (bus),
    .rx_ready_int (rx_ready_int),
    .w_state_dbg  (w_state_dbg),
    .r_state_dbg  (r_state_dbg)
  );

  always #5 aclk = ~aclk;

  int          errors = 0;
  int          checks = 0;
  int          last_at;
  logic [31:0] exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] wr_buf[$];
  logic [1:0]  resp;
  logic [1:0]  resp2;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_at(input int i);
    if (i < rd_q.size()) return rd_q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic fill(input logic [31:0] base, input int n);
    wr_buf.delete();
    for (int i = 0; i < n; i++) wr_buf.push_back(base + 32'(i));
  endtask

  task automatic model_push(input int n);
    for (int i = 0; i < n; i++)
      if (exp_q.size() < DEPTH) exp_q.push_back(wr_buf[i]);
  endtask

  // Compare the last read burst: n_data words from the model, then n_zero zero beats.
  task automatic check_burst(input string tag, input int n_data, input int n_zero);
    logic [31:0] e;
    chk({tag, "_len"}, 32'(rd_q.size()), 32'(n_data + n_zero));
    chk({tag, "_rlast"}, 32'(last_at), 32'(n_data + n_zero - 1));
    for (int i = 0; i < n_data + n_zero; i++) begin
      e = (i < n_data) ? exp_q.pop_front() : 32'h0;
      chk(tag, rd_at(i), e);
    end
  endtask

  task automatic aw_phase(input logic [3:0] addr);
    int t = 0;
    bus.awaddr  = {28'h1234567, addr};
    bus.awvalid = 1'b1;
    @(negedge aclk);
    while (!bus.awready && t < 64) begin @(negedge aclk); t++; end
    chk("aw_handshake", 32'(bus.awready), 32'h1);
    @(posedge aclk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic last);
    int t = 0;
    bus.wdata  = d;
    bus.wlast  = last;
    bus.wvalid = 1'b1;
    @(negedge aclk);
    while (!bus.wready && t < 64) begin @(negedge aclk); t++; end
    chk("w_handshake", 32'(bus.wready), 32'h1);
    @(posedge aclk); #1;
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
  endtask

  task automatic b_phase(input int hold, output logic [1:0] r);
    int t = 0;
    bus.bready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      chk("bvalid_hold", 32'(bus.bvalid), 32'h1);
      @(posedge aclk); #1;
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    while (!bus.bvalid && t < 64) begin @(negedge aclk); t++; end
    chk("b_handshake", 32'(bus.bvalid), 32'h1);
    r = bus.bresp;
    @(posedge aclk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] addr, input int n, input int hold, output logic [1:0] r);
    aw_phase(addr);
    for (int i = 0; i < n; i++) w_beat(wr_buf[i], (i == n - 1));
    b_phase(hold, r);
  endtask

  task automatic ar_phase(input logic [3:0] addr);
    int t = 0;
    bus.araddr  = {28'h7654321, addr};
    bus.arvalid = 1'b1;
    @(negedge aclk);
    while (!bus.arready && t < 64) begin @(negedge aclk); t++; end
    chk("ar_handshake", 32'(bus.arready), 32'h1);
    @(posedge aclk); #1;
    bus.arvalid = 1'b0;
  endtask

  // pat bit i is rready during cycle i of the data phase; later cycles keep rready high.
  task automatic r_phase(input logic [31:0] pat, input bit check_stable);
    int          cyc     = 0;
    bit          done    = 1'b0;
    bit          stalled = 1'b0;
    logic [31:0] held    = '0;
    rd_q.delete();
    last_at = -1;
    while (!done && cyc < 200) begin
      bus.rready = (cyc < 32) ? pat[cyc[4:0]] : 1'b1;
      @(negedge aclk);
      if (bus.rvalid) begin
        if (stalled && check_stable) chk("rdata_stable", bus.rdata, held);
        if (bus.rready) begin
          rd_q.push_back(bus.rdata);
          stalled = 1'b0;
          if (bus.rlast) begin
            last_at = rd_q.size() - 1;
            done    = 1'b1;
          end
        end else begin
          stalled = 1'b1;
          held    = bus.rdata;
        end
      end
      @(posedge aclk); #1;
      cyc++;
    end
    bus.rready = 1'b0;
    chk("r_done", 32'(done), 32'h1);
  endtask

  task automatic do_read(input logic [3:0] addr, input logic [31:0] pat, input bit check_stable);
    ar_phase(addr);
    r_phase(pat, check_stable);
  endtask

  task automatic read_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    do_read(addr, 32'hFFFF_FFFF, 1'b1);
    chk(tag, rd_at(0), exp);
  endtask

  initial begin
    aresetn     = 1'b0;
    bus.awaddr  = '0; bus.awvalid = 1'b0;
    bus.wdata   = '0; bus.wlast   = 1'b0; bus.wvalid = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0; bus.arvalid = 1'b0;
    bus.rready  = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;

    // Reset in the middle of a write burst
    aw_phase(4'h0);
    w_beat(32'h1111_1111, 1'b0);
    w_beat(32'h2222_2222, 1'b0);
    #2 aresetn = 1'b0;
    #1;
    chk("rst_awready", 32'(bus.awready), 32'h0);
    chk("rst_wready",  32'(bus.wready),  32'h0);
    chk("rst_bvalid",  32'(bus.bvalid),  32'h0);
    chk("rst_bresp",   32'(bus.bresp),   32'h0);
    chk("rst_arready", 32'(bus.arready), 32'h0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'h0);
    chk("rst_rlast",   32'(bus.rlast),   32'h0);
    chk("rst_rdata",   bus.rdata,        32'h0);
    chk("rst_rx_int",  32'(rx_ready_int), 32'h0);
    chk("rst_w_state", 32'(w_state_dbg), 32'h0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(posedge aclk); #1;
    read_reg("rst_count", 4'h4, 32'h0);
    read_reg("rst_status", 4'h8, 32'h1);

    // Five-word push and readback
    wr_buf = '{32'h1234_5678, 32'hFFFF_88E3, 32'h5678_9ABC, 32'h0800_4500, 32'h0024_88E3};
    do_write(4'h0, 5, 0, resp);
    model_push(5);
    chk("push5_bresp", 32'(resp), 32'h0);
    chk("push5_rx_int", 32'(rx_ready_int), 32'h1);
    read_reg("push5_count", 4'h4, 32'd5);
    do_read(4'h0, 32'hFFFF_FFFF, 1'b1);
    check_burst("push5_data", 5, 0);
    read_reg("push5_status", 4'h8, 32'h1);

    // Overflow: DEPTH+2 words, the last two are dropped
    fill(32'hA500_0000, DEPTH + 2);
    do_write(4'h0, DEPTH + 2, 0, resp);
    model_push(DEPTH + 2);
    chk("ovf_bresp", 32'(resp), 32'h2);
    read_reg("ovf_status", 4'h8, 32'h2);
    read_reg("ovf_count", 4'h4, 32'(DEPTH));
    do_read(4'h0, 32'hFFFF_FFFF, 1'b1);
    check_burst("ovf_data_a", MAX_RBURST, 0);
    do_read(4'h0, 32'hFFFF_FFFF, 1'b1);
    check_burst("ovf_data_b", MAX_RBURST, 0);
    read_reg("ovf_status_empty", 4'h8, 32'h1);

    // Empty read gives one zero beat without popping
    do_read(4'h0, 32'hFFFF_FFFF, 1'b1);
    check_burst("empty_rd", 0, 1);
    read_reg("empty_count", 4'h4, 32'h0);

    // Burst length is capped at MAX_RBURST
    fill(32'hC000_0000, 20);
    do_write(4'h0, 20, 0, resp);
    model_push(20);
    chk("cap_bresp", 32'(resp), 32'h0);
    read_reg("cap_count20", 4'h4, 32'd20);
    do_read(4'h0, 32'hFFFF_FFFF, 1'b1);
    check_burst("cap_data16", MAX_RBURST, 0);
    read_reg("cap_count4", 4'h4, 32'd4);
    do_read(4'h0, 32'hFFFF_FFFF, 1'b1);
    check_burst("cap_data4", 4, 0);

    // Backpressure on both the B and R channels
    fill(32'h3C00_0010, 3);
    do_write(4'h0, 3, 5, resp);
    model_push(3);
    chk("bp_bresp", 32'(resp), 32'h0);
    do_read(4'h0, 32'hFFFF_FFE5, 1'b1);
    check_burst("bp_data", 3, 0);
    read_reg("bp_count", 4'h4, 32'h0);

    // Unmapped offset: write is rejected, read returns zero
    wr_buf = '{32'hFFFF_FFFF};
    do_write(4'h6, 1, 0, resp);
    chk("unmapped_bresp", 32'(resp), 32'h2);
    read_reg("unmapped_rd", 4'h6, 32'h0);
    read_reg("unmapped_count", 4'h4, 32'h0);

    // Read burst concurrent with a write burst
    fill(32'hAA00_0000, 4);
    do_write(4'h0, 4, 0, resp);
    model_push(4);
    fill(32'hBB00_0000, 4);
    model_push(4);
    fork
      do_write(4'h0, 4, 0, resp);
      do_read(4'h0, 32'hFFFF_FFFF, 1'b1);
    join
    check_burst("conc_data", 4, 0);
    chk("conc_bresp", 32'(resp), 32'h0);
    read_reg("conc_count", 4'h4, 32'd4);

    // CTRL flush while a read burst is stalled after two beats
    wr_buf = '{32'h0000_0001};
    fork
      do_read(4'h0, 32'hFFC0_0003, 1'b0);
      begin
        repeat (5) @(posedge aclk);
        #1;
        do_write(4'hC, 1, 0, resp2);
      end
    join
    check_burst("flush_data", 2, 2);
    exp_q.delete();
    chk("flush_bresp", 32'(resp2), 32'h0);
    read_reg("flush_count", 4'h4, 32'h0);
    chk("flush_rx_int", 32'(rx_ready_int), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
